// File: rtl/mem_stage.sv
// Memory stage of the 16-bit datapath: issues a request/acknowledge data-memory
// transaction for loads/stores, stalls upstream while busy, registers writeback.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ALU_result,
    input  logic [15:0] read2data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        flush,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic        err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic        kill, kill_next;
    logic        req_next, wr_next, wbv_next, err_next;
    logic [15:0] addr_next, wdata_next, wbd_next;
    logic        acc;

    assign acc   = ex_valid & (mem_read | mem_write) & ~flush;
    assign stall = ((state == IDLE) & acc & ~ALU_result[0]) | (state == BUSY);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        kill_next  = kill;
        req_next   = mem_req;
        wr_next    = mem_wr;
        addr_next  = mem_addr;
        wdata_next = mem_wdata;
        wbv_next   = 1'b0;
        wbd_next   = wb_data;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                kill_next = 1'b0;
                if (acc) begin
                    if (ALU_result[0]) begin
                        err_next = 1'b1;
                        wbv_next = 1'b1;
                        wbd_next = '0;
                    end else begin
                        req_next   = 1'b1;
                        wr_next    = mem_write;
                        addr_next  = ALU_result;
                        wdata_next = read2data;
                        cnt_next   = '0;
                        state_next = BUSY;
                    end
                end else if (ex_valid & ~flush) begin
                    wbv_next = 1'b1;
                    wbd_next = ALU_result;
                end
            end
            BUSY: begin
                if (flush) kill_next = 1'b1;
                if (mem_ack) begin
                    // a flush arriving in the ack cycle squashes the result too
                    req_next   = 1'b0;
                    kill_next  = 1'b0;
                    state_next = IDLE;
                    if (!(kill | flush)) begin
                        wbv_next = 1'b1;
                        wbd_next = mem_wr ? mem_addr : mem_rdata;
                    end
                end else if (cnt == CNT_LAST) begin
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    kill_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            kill      <= 1'b0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            kill      <= kill_next;
            mem_req   <= req_next;
            mem_wr    <= wr_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            wb_valid  <= wbv_next;
            wb_data   <= wbd_next;
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected writeback/error pulses go into a queue
// that an independent monitor drains; handshake timing is checked inline.
module tb_mem_stage;

    typedef struct {
        logic        valid;
        logic        error;
        logic        check_data;
        logic [15:0] data;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ALU_result;
    logic [15:0] read2data;
    logic        mem_read;
    logic        mem_write;
    logic        flush;
    logic        stall;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        err;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    wb_exp_t     exp_q[$];

    mem_stage #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ALU_result(ALU_result),
        .read2data (read2data),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .flush     (flush),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic v, input logic e, input logic cd, input logic [15:0] d);
        wb_exp_t x;
        x.valid = v; x.error = e; x.check_data = cd; x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        ALU_result = '0; read2data = '0;
    endtask

    // Monitor: every writeback or error pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (wb_valid === 1'b1 || err === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got wb_valid=%0b err=%0b wb_data=0x%04h expected no pulse at %0t",
                         wb_valid, err, wb_data, $time);
            end else begin
                wb_exp_t x;
                x = exp_q.pop_front();
                check("mon_wb_valid", 16'(wb_valid), 16'(x.valid));
                check("mon_err", 16'(err), 16'(x.error));
                if (x.check_data) check("mon_wb_data", wb_data, x.data);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        clear_ex();
        tick(); tick();
        check("rst_mem_req", 16'(mem_req), 16'd0);
        check("rst_mem_wr", 16'(mem_wr), 16'd0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_wb_valid", 16'(wb_valid), 16'd0);
        check("rst_wb_data", wb_data, 16'h0000);
        check("rst_err", 16'(err), 16'd0);
        check("rst_stall", 16'(stall), 16'd0);
        rst = 1'b0;
        tick();

        // non-memory pass-through
        ex_valid = 1'b1; ALU_result = 16'h1234;
        #1 check("alu_stall_in", 16'(stall), 16'd0);
        expect_wb(1'b1, 1'b0, 1'b1, 16'h1234);
        tick(); clear_ex();
        check("alu_stall_out", 16'(stall), 16'd0);
        check("alu_no_req", 16'(mem_req), 16'd0);
        tick();

        // aligned load, ack in the third request cycle
        ex_valid = 1'b1; mem_read = 1'b1; ALU_result = 16'h0040;
        #1 check("ld_stall_accept", 16'(stall), 16'd1);
        expect_wb(1'b1, 1'b0, 1'b1, 16'hBEEF);
        tick(); clear_ex();
        for (int i = 0; i < 3; i++) begin
            check("ld_mem_req", 16'(mem_req), 16'd1);
            check("ld_mem_addr", mem_addr, 16'h0040);
            check("ld_mem_wr", 16'(mem_wr), 16'd0);
            check("ld_stall_busy", 16'(stall), 16'd1);
            if (i == 2) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
            tick();
        end
        mem_ack = 1'b0; mem_rdata = '0;
        check("ld_req_drop", 16'(mem_req), 16'd0);
        check("ld_stall_drop", 16'(stall), 16'd0);
        tick();

        // store with immediate ack; returns the address
        ex_valid = 1'b1; mem_write = 1'b1; ALU_result = 16'h0100; read2data = 16'h00AA;
        expect_wb(1'b1, 1'b0, 1'b1, 16'h0100);
        tick(); clear_ex();
        check("st_mem_req", 16'(mem_req), 16'd1);
        check("st_mem_wr", 16'(mem_wr), 16'd1);
        check("st_mem_wdata", mem_wdata, 16'h00AA);
        check("st_mem_addr", mem_addr, 16'h0100);
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("st_req_drop", 16'(mem_req), 16'd0);
        tick();

        // misaligned load
        ex_valid = 1'b1; mem_read = 1'b1; ALU_result = 16'h0041;
        #1 check("mis_stall", 16'(stall), 16'd0);
        expect_wb(1'b1, 1'b1, 1'b1, 16'h0000);
        tick(); clear_ex();
        check("mis_no_req", 16'(mem_req), 16'd0);
        tick();
        check("mis_no_req2", 16'(mem_req), 16'd0);

        // timeout (TIMEOUT=4) and a late ack
        ex_valid = 1'b1; mem_read = 1'b1; ALU_result = 16'h0200;
        expect_wb(1'b0, 1'b1, 1'b0, 16'h0000);
        tick(); clear_ex();
        for (int i = 0; i < 4; i++) begin
            check("to_mem_req", 16'(mem_req), 16'd1);
            tick();
        end
        check("to_req_drop", 16'(mem_req), 16'd0);
        check("to_stall_drop", 16'(stall), 16'd0);
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("to_late_ack_req", 16'(mem_req), 16'd0);
        tick(); tick();

        // flush in second busy cycle, then ack: result squashed
        ex_valid = 1'b1; mem_read = 1'b1; ALU_result = 16'h0300;
        tick(); clear_ex();
        check("fl_stall_b1", 16'(stall), 16'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        check("fl_stall_ack", 16'(stall), 16'd1);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("fl_stall_drop", 16'(stall), 16'd0);
        check("fl_req_drop", 16'(mem_req), 16'd0);
        tick();

        // next load must not inherit the squash
        ex_valid = 1'b1; mem_read = 1'b1; ALU_result = 16'h0400;
        expect_wb(1'b1, 1'b0, 1'b1, 16'h4242);
        tick(); clear_ex();
        mem_ack = 1'b1; mem_rdata = 16'h4242;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        tick();

        // reset while busy
        ex_valid = 1'b1; mem_write = 1'b1; ALU_result = 16'h0500; read2data = 16'h0077;
        tick(); clear_ex();
        check("rb_mem_req", 16'(mem_req), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rb_mem_req0", 16'(mem_req), 16'd0);
        check("rb_mem_wr0", 16'(mem_wr), 16'd0);
        check("rb_mem_addr0", mem_addr, 16'h0000);
        check("rb_mem_wdata0", mem_wdata, 16'h0000);
        check("rb_wb_data0", wb_data, 16'h0000);
        check("rb_stall0", 16'(stall), 16'd0);
        ex_valid = 1'b1; ALU_result = 16'hA5A5;
        expect_wb(1'b1, 1'b0, 1'b1, 16'hA5A5);
        tick(); clear_ex();
        tick(); tick();

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the execute stage's outputs in the 16-bit datapath.
- Takes ALU_result as the data address, takes read2data as store data, and runs a multi-cycle request/acknowledge transaction to data memory.
- Stalls upstream while the transaction is outstanding, then delivers a registered writeback result.
- Non-memory instructions pass their ALU_result through with one cycle of latency.

Parameters:
- TIMEOUT, 16: maximum cycles spent in BUSY waiting for mem_ack before an error is raised (1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- ex_valid  input  1  execute stage presents a valid instruction this cycle.
- ALU_result  input  16  address for memory ops; result for non-memory ops.
- read2data  input  16  store data.
- mem_read  input  1  instruction is a load.
- mem_write  input  1  instruction is a store.
- flush  input  1  squash the instruction presented or in flight.
- stall  output  1  combinational; upstream must hold its outputs while 1.
- mem_req  output  1  registered request to data memory.
- mem_wr  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  16  registered address.
- mem_wdata  output  16  registered store data.
- mem_ack  input  1  memory completes the request; sampled only while mem_req=1.
- mem_rdata  input  16  load data; valid in the cycle mem_ack=1.
- wb_valid  output  1  one-cycle pulse: wb_data is valid.
- wb_data  output  16  load data or passed-through ALU_result.
- err  output  1  one-cycle pulse on misaligned access or timeout.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0, kill flag 0. Reset asserted in any state, including BUSY, forces IDLE on the next edge; mem_req drops that edge and no wb_valid is produced for the aborted op.
- States: IDLE and BUSY.
- Define acc = ex_valid & (mem_read | mem_write) & ~flush. mem_read and mem_write both 1 is treated as a store.
- stall = (state==IDLE & acc & ~ALU_result[0]) | (state==BUSY).
- IDLE, ex_valid & flush: nothing is registered; wb_valid=0 next cycle.
- IDLE, non-memory op (ex_valid, ~mem_read, ~mem_write, ~flush):
  - Next cycle wb_valid=1 and wb_data=ALU_result.
  - Latency 1, no stall.
- IDLE, acc with ALU_result[0]=1 (misaligned):
  - No request is issued.
  - Next cycle err=1, wb_valid=1, wb_data=0.
  - stall stays 0.
- IDLE, aligned acc:
  - Latch mem_addr=ALU_result, mem_wdata=read2data, mem_wr=mem_write.
  - Set mem_req=1, clear the counter, go to BUSY.
- BUSY:
  - mem_req, mem_wr, mem_addr and mem_wdata are held constant.
  - Counter increments each cycle without ack.
- BUSY and mem_ack=1:
  - Next edge: mem_req=0, state IDLE.
  - wb_valid=1 unless the kill flag is set.
  - wb_data = mem_rdata for a load, or mem_addr for a store.
  - Minimum memory-op latency: request in cycle N+1; ack in N+1 gives wb_valid in N+2.
- BUSY and counter == TIMEOUT-1 with no ack:
  - Next edge: mem_req=0, err=1, wb_valid=0, state IDLE.
  - A late mem_ack arriving after that edge is ignored.
- flush while BUSY:
  - The transaction is not aborted; memory still completes it.
  - The kill flag is set, which suppresses wb_valid on completion.
  - The kill flag is cleared on return to IDLE.
- The new input sampled on the ack cycle is not accepted, because stall=1 in BUSY. The next instruction is accepted in the following IDLE cycle.
- wb_valid and err are single-cycle pulses and are 0 in every other cycle. wb_data holds its last value when wb_valid=0.
- Address arithmetic: none. The address is passed 16-bit unchanged, and bit 0 is the alignment check.

Test Plan:
- Reset then non-memory op: ex_valid=1, ALU_result=0x1234 -> next cycle wb_valid=1, wb_data=0x1234, stall=0 throughout.
- Aligned load:
  - Stimulus: ALU_result=0x0040, mem_read=1; memory acks 3 cycles after mem_req rises with rdata=0xBEEF.
  - Required: mem_req=1 and mem_addr=0x0040 for exactly 3 cycles; stall=1 from the accept cycle through the ack cycle; wb_valid=1 with wb_data=0xBEEF the cycle after ack.
- Store:
  - Stimulus: ALU_result=0x0100, read2data=0x00AA, mem_write=1, immediate ack.
  - Required: mem_wr=1, mem_wdata=0x00AA for 1 cycle; wb_valid pulse with wb_data=0x0100.
- Misaligned load: ALU_result=0x0041, mem_read=1 -> mem_req never rises; next cycle err=1, wb_valid=1, wb_data=0.
- Timeout: TIMEOUT=4, load with mem_ack held 0 -> mem_req high 4 cycles, then err pulse, wb_valid=0, state IDLE; an ack 2 cycles later is ignored.
- Flush and reset mid-op:
  - Flush in the 2nd BUSY cycle, then ack -> no wb_valid pulse, stall drops after ack.
  - Separately, rst in BUSY -> next cycle mem_req=0, all outputs 0, and a following non-memory op completes normally.
